// File: rtl/cube_layer_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : cube_layer_ctl_if
// Description : Byte-stream and RAM write-control bundle between the SPI byte
//               receiver (master) and the cube layer controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cube_layer_ctl_if #(
  parameter int LAYERS      = 8,
  parameter int ADDR_WIDTH  = 6,
  parameter int COLOR_BYTES = 3
);
  logic                   dc_in;
  logic                   byte_rdy_in;
  logic [7:0]             byte_data_in;
  logic                   frame_rdy_out;
  logic                   frame_err_out;
  logic                   busy_out;
  logic [ADDR_WIDTH-1:0]  wr_addr_out;
  logic [COLOR_BYTES:0]   byte_en_out;
  logic [LAYERS-1:0]      layer_en_out;

  // Byte source side: presents bytes, observes the write controls.
  modport master (
    output dc_in, byte_rdy_in, byte_data_in,
    input  frame_rdy_out, frame_err_out, busy_out,
    input  wr_addr_out, byte_en_out, layer_en_out
  );

  // Controller side.
  modport slave (
    input  dc_in, byte_rdy_in, byte_data_in,
    output frame_rdy_out, frame_err_out, busy_out,
    output wr_addr_out, byte_en_out, layer_en_out
  );
endinterface
`default_nettype wire

// File: rtl/cube_layer_ctl.sv
`default_nettype none
// ============================================================================
// Module      : cube_layer_ctl
// Description : LED cube frame loader byte router. Decodes command/data bytes
//               and produces per-byte RAM write address, byte-lane enables
//               and layer enables. Supports address-map writes, full frame
//               writes, partial frame writes from a selected start layer and
//               a frame-abort error pulse.
//               Optional macro CUBE_LAYER_CTL_ASCEND_EN: layers are filled in
//               ascending order (layer 0 first) instead of descending.
// Revision    : 1.0 - initial release
// ============================================================================
module cube_layer_ctl #(
  parameter int         LAYERS        = 8,
  parameter int         ADDR_WIDTH    = 6,
  parameter int         COLOR_BYTES   = 3,
  parameter logic [7:0] CMD_ADDR_WR   = 8'hcc,
  parameter logic [7:0] CMD_DATA_WR   = 8'hda,
  parameter logic [7:0] CMD_LAYER_SEL = 8'hca
) (
  input wire              clk_in,
  input wire              rst_in,
  cube_layer_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_LSEL = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = '1;
  localparam logic [COLOR_BYTES-1:0] COLOUR_MSB = COLOR_BYTES'(1) << (COLOR_BYTES - 1);

`ifdef CUBE_LAYER_CTL_ASCEND_EN
  // Ascending fill: start at layer 0, finish on layer LAYERS-1.
  localparam logic [LAYERS-1:0] LAYER_START   = LAYERS'(1);
  localparam int                LAYER_END_BIT = LAYERS - 1;
`else
  // Descending fill: start at layer LAYERS-1, finish on layer 0.
  localparam logic [LAYERS-1:0] LAYER_START   = LAYERS'(1) << (LAYERS - 1);
  localparam int                LAYER_END_BIT = 0;
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                    addr_en_q, addr_en_d;
  logic [COLOR_BYTES-1:0]  colour_q, colour_d;
  logic [LAYERS-1:0]       layer_q, layer_d;
  logic                    data_seen_q, data_seen_d;
  logic                    frame_rdy_q, frame_rdy_d;
  logic                    frame_err_q, frame_err_d;
  logic                    busy_q;

  logic [LAYERS-1:0]       layer_adv;
  logic [COLOR_BYTES-1:0]  colour_rot;
  logic                    lsel_valid;

  // Next layer in fill order once the current layer has been completed.
`ifdef CUBE_LAYER_CTL_ASCEND_EN
  assign layer_adv = layer_q << 1;
`else
  assign layer_adv = layer_q >> 1;
`endif

  // Rotate-right of the colour lane; a single-byte pixel keeps its one lane.
  assign colour_rot = (colour_q >> 1) | (colour_q << (COLOR_BYTES - 1));
  assign lsel_valid = int'({24'd0, bus.byte_data_in}) < LAYERS;

  // Byte decoder: registers advance only when a byte is strobed in.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    addr_en_d   = addr_en_q;
    colour_d    = colour_q;
    layer_d     = layer_q;
    data_seen_d = data_seen_q;
    frame_rdy_d = 1'b0;
    frame_err_d = 1'b0;

    if (bus.byte_rdy_in) begin
      if (!bus.dc_in) begin
        // Commands are honoured in any state; interrupting a frame that has
        // already received data is reported, then decoded as usual.
        wr_addr_d   = '0;
        data_seen_d = 1'b0;
        if (state_q == ST_DATA && data_seen_q) begin
          frame_err_d = 1'b1;
        end
        case (bus.byte_data_in)
          CMD_ADDR_WR: begin
            state_d   = ST_ADDR;
            addr_en_d = 1'b1;
            colour_d  = '0;
            layer_d   = '1;
          end
          CMD_DATA_WR: begin
            state_d   = ST_DATA;
            addr_en_d = 1'b0;
            colour_d  = COLOUR_MSB;
            layer_d   = LAYER_START;
          end
          CMD_LAYER_SEL: begin
            state_d   = ST_LSEL;
            addr_en_d = 1'b0;
            colour_d  = '0;
            layer_d   = '0;
          end
          default: begin
            state_d   = ST_IDLE;
            addr_en_d = 1'b0;
            colour_d  = '0;
            layer_d   = '0;
          end
        endcase
      end else begin
        case (state_q)
          ST_ADDR: begin
            if (wr_addr_q == LAST_ADDR) begin
              wr_addr_d = '0;
              layer_d   = '0;
              addr_en_d = 1'b0;
              state_d   = ST_IDLE;
            end else begin
              wr_addr_d = wr_addr_q + 1'b1;
            end
          end
          ST_LSEL: begin
            // The data byte carries the start layer index.
            if (lsel_valid) begin
              state_d  = ST_DATA;
              layer_d  = LAYERS'(1) << bus.byte_data_in;
              colour_d = COLOUR_MSB;
            end else begin
              state_d     = ST_IDLE;
              frame_err_d = 1'b1;
              layer_d     = '0;
              colour_d    = '0;
            end
          end
          ST_DATA: begin
            data_seen_d = 1'b1;
            colour_d    = colour_rot;
            // The last colour byte of a pixel moves to the next pixel.
            if (colour_q[0]) begin
              wr_addr_d = wr_addr_q + 1'b1;
              if (wr_addr_q == LAST_ADDR) begin
                if (layer_q[LAYER_END_BIT]) begin
                  layer_d     = '0;
                  state_d     = ST_IDLE;
                  frame_rdy_d = 1'b1;
                end else begin
                  layer_d = layer_adv;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      addr_en_q   <= 1'b0;
      colour_q    <= '0;
      layer_q     <= '0;
      data_seen_q <= 1'b0;
      frame_rdy_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      addr_en_q   <= addr_en_d;
      colour_q    <= colour_d;
      layer_q     <= layer_d;
      data_seen_q <= data_seen_d;
      frame_rdy_q <= frame_rdy_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign bus.wr_addr_out   = wr_addr_q;
  assign bus.byte_en_out   = {addr_en_q, colour_q};
  assign bus.layer_en_out  = layer_q & {LAYERS{bus.byte_rdy_in}};
  assign bus.frame_rdy_out = frame_rdy_q;
  assign bus.frame_err_out = frame_err_q;
  assign bus.busy_out      = busy_q;

endmodule
`default_nettype wire

// File: doc/cube_layer_ctl.md
Name: cube_layer_ctl

Overview:
- Parametrised byte-stream router for the LED cube frame loader; sits between the SPI byte receiver and the per-layer RAM banks.
- Decodes command/data bytes and generates the per-byte write address, byte-lane enables and layer enables.
- Generalises the fixed 8-layer/64-pixel/RGB controller to arbitrary layer count, layer depth and bytes per pixel.
- Adds a start-layer select command (partial frame update) and a frame-abort error pulse.

Parameters:
LAYERS, 8, number of layers (>=2)
ADDR_WIDTH, 6, pixel address width; pixels per layer = 2**ADDR_WIDTH
COLOR_BYTES, 3, data bytes per pixel (>=1)
CMD_ADDR_WR, 8'hcc, command: write address map to all layers
CMD_DATA_WR, 8'hda, command: write full frame data
CMD_LAYER_SEL, 8'hca, command: write frame data from selected layer

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-high
dc_in  in  1  0 = command byte, 1 = data byte; sampled only when byte_rdy_in=1
byte_rdy_in  in  1  single-cycle byte strobe
byte_data_in  in  8  received byte
frame_rdy_out  out  1  one-cycle pulse: frame/partial frame complete
frame_err_out  out  1  one-cycle pulse: data frame aborted by a command
busy_out  out  1  1 while in ADDR, LSEL or DATA
wr_addr_out  out  ADDR_WIDTH  RAM write address for the current byte
byte_en_out  out  COLOR_BYTES+1  {addr_en, colour one-hot}, lane for the current byte
layer_en_out  out  LAYERS  layer enable AND byte_rdy_in (replicated)

Behaviour:
- Reset (async, rst_in=1): state IDLE; wr_addr_out=0, byte_en_out=0, layer_en_out=0, frame_rdy_out=0, frame_err_out=0, busy_out=0. Reset mid-frame discards all progress.
- Internal registers (state, wr_addr, addr_en, colour, layer) update only on clk_in edges where byte_rdy_in=1. Outputs describe the byte presented in the same cycle; the new value applies to the next byte.
- States: IDLE, ADDR, LSEL, DATA.
- Command byte (dc_in=0), accepted in any state:
  - wr_addr <= 0.
  - CMD_ADDR_WR -> ADDR: addr_en=1, colour=0, layer=all ones.
  - CMD_DATA_WR -> DATA: addr_en=0, colour=MSB one-hot, layer=one-hot bit LAYERS-1.
  - CMD_LAYER_SEL -> LSEL: enables=0.
  - Any other value -> IDLE, all enables 0.
- Data byte in IDLE: ignored.
- Data byte in ADDR: wr_addr+1. The byte at address 2**ADDR_WIDTH-1 wraps wr_addr to 0, clears layer and addr_en, goes to IDLE. No frame_rdy.
- Data byte in LSEL: byte_data_in is the start layer index.
  - Index < LAYERS -> DATA with layer=one-hot(index), colour=MSB.
  - Index >= LAYERS -> frame_err pulse, go to IDLE.
  - layer_en_out=0 for this byte.
- Data byte in DATA:
  - colour rotates right (wraps bit 0 -> MSB). wr_addr increments only on the bit-0 byte.
  - On the bit-0 byte at the last address: wr_addr -> 0.
  - If layer bit 0 is set: layer=0, IDLE, frame_rdy pulse. Otherwise layer shifts right by one.
- frame_rdy_out / frame_err_out are registered: high exactly one cycle, the cycle after the triggering byte edge.
- Abort: a command accepted in DATA after at least one DATA byte -> frame_err pulse, then the command is decoded normally (same edge). A command in DATA before any data byte is not an error.
- COLOR_BYTES=1: colour stays constant; every DATA byte advances wr_addr.
- busy_out = (state != IDLE), registered.

Optional Feature:
- Macro CUBE_LAYER_CTL_ASCEND_EN.
- Defined:
  - CMD_DATA_WR starts at layer 0; layer shifts left.
  - Completion when the byte finishing layer LAYERS-1 is accepted.
  - LSEL start index scans upward.
- Undefined: descending order as specified above.

Test Plan:
- Defaults; cmd 8'hda then 8*64*3=1536 data bytes:
  - layer_en_out=8'h80 for bytes 0-191, 8'h40 next, ... 8'h01 last.
  - wr_addr steps 0..63 per layer; byte_en_out cycles 4'b0100,0010,0001.
  - One frame_rdy pulse one cycle after byte 1536; busy_out=0 after.
- Cmd 8'hcc then 64 data bytes:
  - layer_en_out=8'hff and byte_en_out=4'b1000 on each byte; wr_addr 0..63.
  - IDLE after; no frame_rdy.
- Cmd 8'hca, data 8'h02, then 3*64*3=576 bytes: layers 8'h04,8'h02,8'h01 in order; frame_rdy after byte 576.
- Cmd 8'hca, data 8'h09: frame_err pulse, IDLE, no layer enable on that byte.
- Cmd 8'hda, 100 data bytes, cmd 8'hcc: frame_err pulse one cycle later; wr_addr=0, byte_en_out=4'b1000.
- rst_in asserted mid-DATA with byte_rdy_in idle: all outputs 0 immediately (async). First data byte after release is ignored (IDLE).
